// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencer.
package pipe_ctrl_pkg;

    localparam int PC_W_DEF  = 32;
    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        REDIR_PEND = 2'd2
    } pc_state_e;

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter with synchronous clear; wraps modulo 2^W.
module perf_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else if (i_inc) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: merges stall, redirect and memory-wait sources into
// stage enables, bubbles and PC control, plus stall/flush counters.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_hz_stall,
    input  logic             i_redirect_valid,
    input  logic [PC_W-1:0]  i_redirect_pc,
    input  logic             i_imem_ready,
    input  logic             i_dmem_req,
    input  logic             i_dmem_ready,
    output logic             o_en_if,
    output logic             o_en_id,
    output logic             o_en_ex,
    output logic             o_en_mem,
    output logic             o_en_wb,
    output logic             o_flush_if_id,
    output logic             o_flush_id_ex,
    output logic             o_pc_we,
    output logic             o_pc_sel,
    output logic [PC_W-1:0]  o_redirect_pc,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    pc_state_e       state_q, state_d;
    logic [PC_W-1:0] pend_pc_q, pend_pc_d;
    logic            dwait;

    assign dwait = i_dmem_req & ~i_dmem_ready;

    always_comb begin
        state_d       = state_q;
        pend_pc_d     = pend_pc_q;
        o_en_if       = 1'b1;
        o_en_id       = 1'b1;
        o_en_ex       = 1'b1;
        o_en_mem      = 1'b1;
        o_en_wb       = 1'b1;
        o_flush_if_id = 1'b0;
        o_flush_id_ex = 1'b0;
        o_pc_we       = 1'b0;
        o_pc_sel      = 1'b0;
        o_redirect_pc = '0;

        if (dwait) begin
            // Whole pipe freezes; a RUN-state redirect is simply re-presented later.
            {o_en_if, o_en_id, o_en_ex, o_en_mem, o_en_wb} = '0;
            if (state_q == RUN) state_d = MEM_WAIT;
        end else if (state_q == REDIR_PEND) begin
            o_redirect_pc = pend_pc_q;
            o_pc_sel      = 1'b1;
            if (i_hz_stall) begin
                o_en_if       = 1'b0;
                o_en_id       = 1'b0;
                o_flush_id_ex = 1'b1;
            end else if (i_imem_ready) begin
                o_pc_we       = 1'b1;
                o_flush_if_id = 1'b1;
                state_d       = RUN;
            end else begin
                o_en_if       = 1'b0;
                o_flush_if_id = 1'b1;
            end
        end else begin
            // RUN, or MEM_WAIT in the cycle the data access completes.
            state_d = RUN;
            if (i_hz_stall) begin
                o_en_if       = 1'b0;
                o_en_id       = 1'b0;
                o_flush_id_ex = 1'b1;
            end else if (i_redirect_valid) begin
                o_redirect_pc = i_redirect_pc;
                o_flush_if_id = 1'b1;
                if (i_imem_ready) begin
                    o_pc_we  = 1'b1;
                    o_pc_sel = 1'b1;
                end else begin
                    o_en_if   = 1'b0;
                    pend_pc_d = i_redirect_pc;
                    state_d   = REDIR_PEND;
                end
            end else if (!i_imem_ready) begin
                o_en_if       = 1'b0;
                o_flush_if_id = 1'b1;
            end else begin
                o_pc_we = 1'b1;
            end
        end

        if (i_reset) begin
            {o_en_if, o_en_id, o_en_ex, o_en_mem, o_en_wb} = '0;
            o_flush_if_id = 1'b1;
            o_flush_id_ex = 1'b1;
            o_pc_we       = 1'b0;
            o_pc_sel      = 1'b0;
            o_redirect_pc = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= RUN;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign o_busy = (state_q != RUN);

    perf_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (~o_en_id),
        .o_cnt   (o_stall_cnt)
    );

    perf_counter #(.W(CNT_W)) u_flush_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (o_pc_we & o_pc_sel),
        .o_cnt   (o_flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (32-bit and 4-bit counter builds).
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst, hz, rv, imem, dreq, drdy;
    logic [31:0] rpc;

    logic        en_if, en_id, en_ex, en_mem, en_wb, fif, fix, we, sel, busy;
    logic [31:0] rpc_o, scnt, fcnt;
    logic        b_en_if, b_en_id, b_en_ex, b_en_mem, b_en_wb, b_fif, b_fix, b_we, b_sel, b_busy;
    logic [31:0] b_rpc_o;
    logic [3:0]  b_scnt, b_fcnt;

    int errors = 0;
    int checks = 0;

    logic [8:0] ctrl;
    assign ctrl = {en_if, en_id, en_ex, en_mem, en_wb, fif, fix, we, sel};

    always #5 clk = ~clk;

    pipeline_ctrl #(.PC_W(32), .CNT_W(32)) dut (
        .i_clk(clk), .i_reset(rst), .i_hz_stall(hz), .i_redirect_valid(rv),
        .i_redirect_pc(rpc), .i_imem_ready(imem), .i_dmem_req(dreq), .i_dmem_ready(drdy),
        .o_en_if(en_if), .o_en_id(en_id), .o_en_ex(en_ex), .o_en_mem(en_mem), .o_en_wb(en_wb),
        .o_flush_if_id(fif), .o_flush_id_ex(fix), .o_pc_we(we), .o_pc_sel(sel),
        .o_redirect_pc(rpc_o), .o_busy(busy), .o_stall_cnt(scnt), .o_flush_cnt(fcnt)
    );

    pipeline_ctrl #(.PC_W(32), .CNT_W(4)) dut4 (
        .i_clk(clk), .i_reset(rst), .i_hz_stall(hz), .i_redirect_valid(rv),
        .i_redirect_pc(rpc), .i_imem_ready(imem), .i_dmem_req(dreq), .i_dmem_ready(drdy),
        .o_en_if(b_en_if), .o_en_id(b_en_id), .o_en_ex(b_en_ex), .o_en_mem(b_en_mem), .o_en_wb(b_en_wb),
        .o_flush_if_id(b_fif), .o_flush_id_ex(b_fix), .o_pc_we(b_we), .o_pc_sel(b_sel),
        .o_redirect_pc(b_rpc_o), .o_busy(b_busy), .o_stall_cnt(b_scnt), .o_flush_cnt(b_fcnt)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        hz = 0; rv = 0; rpc = '0; imem = 1; dreq = 0; drdy = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle();
        tick(); tick(); settle();
        checks++; if (ctrl !== 9'b00000_1100) begin errors++; $display("FAIL reset_ctrl got %b exp %b", ctrl, 9'b00000_1100); end
        checks++; if ({scnt, fcnt} !== 64'd0) begin errors++; $display("FAIL reset_cnt got %h exp 0", {scnt, fcnt}); end
        tick(); rst = 0; settle();
        checks++; if (ctrl !== 9'b11111_0010) begin errors++; $display("FAIL post_reset_ctrl got %b exp %b", ctrl, 9'b11111_0010); end
        checks++; if ({busy, rpc_o} !== 33'd0) begin errors++; $display("FAIL post_reset_busy_pc got %h exp 0", {busy, rpc_o}); end
        tick();
        checks++; if (scnt !== 32'd0) begin errors++; $display("FAIL post_reset_stall got %0d exp 0", scnt); end
    endtask

    task automatic test_hz_stall();
        hz = 1; settle();
        checks++; if (ctrl !== 9'b00111_0100) begin errors++; $display("FAIL hz_ctrl got %b exp %b", ctrl, 9'b00111_0100); end
        tick(); hz = 0; settle();
        checks++; if (scnt !== 32'd1) begin errors++; $display("FAIL hz_stall_cnt got %0d exp 1", scnt); end
    endtask

    task automatic test_redirect_ready();
        rv = 1; rpc = 32'h100; settle();
        checks++; if (ctrl !== 9'b11111_1011) begin errors++; $display("FAIL redir_rdy_ctrl got %b exp %b", ctrl, 9'b11111_1011); end
        checks++; if (rpc_o !== 32'h100) begin errors++; $display("FAIL redir_rdy_pc got %h exp 100", rpc_o); end
        tick(); rv = 0; settle();
        checks++; if (fcnt !== 32'd1) begin errors++; $display("FAIL redir_rdy_fcnt got %0d exp 1", fcnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL redir_rdy_busy got %b exp 0", busy); end
    endtask

    task automatic test_redirect_wait();
        rv = 1; rpc = 32'h200; imem = 0; settle();
        checks++; if (ctrl !== 9'b01111_1000) begin errors++; $display("FAIL redir_wait_c0 got %b exp %b", ctrl, 9'b01111_1000); end
        // Second redirect while pending must be ignored.
        tick(); rpc = 32'h300; settle();
        checks++; if ({busy, ctrl} !== 10'b1_01111_1001) begin errors++; $display("FAIL redir_wait_c1 got %b exp %b", {busy, ctrl}, 10'b1_01111_1001); end
        checks++; if (rpc_o !== 32'h200) begin errors++; $display("FAIL redir_wait_pend_pc got %h exp 200", rpc_o); end
        tick(); rv = 0; settle();
        checks++; if ({busy, ctrl} !== 10'b1_01111_1001) begin errors++; $display("FAIL redir_wait_c2 got %b exp %b", {busy, ctrl}, 10'b1_01111_1001); end
        tick(); imem = 1; settle();
        checks++; if ({busy, ctrl} !== 10'b1_11111_1011) begin errors++; $display("FAIL redir_wait_rdy got %b exp %b", {busy, ctrl}, 10'b1_11111_1011); end
        checks++; if (rpc_o !== 32'h200) begin errors++; $display("FAIL redir_wait_rdy_pc got %h exp 200", rpc_o); end
        tick();
        checks++; if ({busy, ctrl} !== 10'b0_11111_0010) begin errors++; $display("FAIL redir_wait_back got %b exp %b", {busy, ctrl}, 10'b0_11111_0010); end
        checks++; if ({fcnt, scnt} !== {32'd2, 32'd1}) begin errors++; $display("FAIL redir_wait_cnts got %h exp %h", {fcnt, scnt}, {32'd2, 32'd1}); end
    endtask

    task automatic test_dmem_wait();
        dreq = 1; drdy = 0; hz = 1; settle();
        checks++; if ({busy, ctrl} !== 10'b0_00000_0000) begin errors++; $display("FAIL dwait_c0 got %b exp %b", {busy, ctrl}, 10'b0_00000_0000); end
        tick();
        checks++; if ({busy, ctrl} !== 10'b1_00000_0000) begin errors++; $display("FAIL dwait_c1 got %b exp %b", {busy, ctrl}, 10'b1_00000_0000); end
        tick(); tick(); drdy = 1; settle();
        checks++; if (scnt !== 32'd4) begin errors++; $display("FAIL dwait_stall_cnt got %0d exp 4", scnt); end
        checks++; if ({busy, ctrl} !== 10'b1_00111_0100) begin errors++; $display("FAIL dwait_release got %b exp %b", {busy, ctrl}, 10'b1_00111_0100); end
        tick(); hz = 0; dreq = 0; drdy = 0; settle();
        checks++; if ({busy, scnt} !== {1'b0, 32'd5}) begin errors++; $display("FAIL dwait_after got %h exp %h", {busy, scnt}, {1'b0, 32'd5}); end
        // Redirect during a freeze is not captured and re-presents afterwards.
        rv = 1; rpc = 32'h400; dreq = 1; settle();
        checks++; if (ctrl !== 9'b00000_0000) begin errors++; $display("FAIL dwait_redir_frz got %b exp %b", ctrl, 9'b00000_0000); end
        tick(); drdy = 1; settle();
        checks++; if ({busy, ctrl, rpc_o} !== {1'b1, 9'b11111_1011, 32'h400}) begin errors++; $display("FAIL dwait_redir_rel got %h exp %h", {busy, ctrl, rpc_o}, {1'b1, 9'b11111_1011, 32'h400}); end
        tick(); idle(); settle();
        checks++; if ({busy, fcnt, scnt} !== {1'b0, 32'd3, 32'd6}) begin errors++; $display("FAIL dwait_redir_cnts got %h exp %h", {busy, fcnt, scnt}, {1'b0, 32'd3, 32'd6}); end
    endtask

    task automatic test_reset_mid();
        rv = 1; rpc = 32'h500; imem = 0; settle();
        tick(); rv = 0; rst = 1; settle();
        checks++; if ({busy, ctrl} !== 10'b1_00000_1100) begin errors++; $display("FAIL mid_reset_ctrl got %b exp %b", {busy, ctrl}, 10'b1_00000_1100); end
        tick(); rst = 0; imem = 1; settle();
        checks++; if ({busy, ctrl, rpc_o} !== {1'b0, 9'b11111_0010, 32'h0}) begin errors++; $display("FAIL mid_reset_after got %h exp %h", {busy, ctrl, rpc_o}, {1'b0, 9'b11111_0010, 32'h0}); end
        checks++; if ({scnt, fcnt, b_scnt} !== 68'd0) begin errors++; $display("FAIL mid_reset_cnts got %h exp 0", {scnt, fcnt, b_scnt}); end
    endtask

    task automatic test_counter_wrap();
        hz = 1;
        for (int i = 0; i < 15; i++) tick();
        checks++; if (b_scnt !== 4'd15) begin errors++; $display("FAIL wrap_15 got %0d exp 15", b_scnt); end
        tick(); hz = 0; settle();
        checks++; if (b_scnt !== 4'd0) begin errors++; $display("FAIL wrap_16 got %0d exp 0", b_scnt); end
        checks++; if (scnt !== 32'd16) begin errors++; $display("FAIL wide_16 got %0d exp 16", scnt); end
    endtask

    initial begin
        rst = 1; idle();
        test_reset();
        test_hz_stall();
        test_redirect_ready();
        test_redirect_wait();
        test_dmem_wait();
        test_reset_mid();
        test_counter_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
